sdram_port_scheduler: RTL

- Round-robin burst scheduler for the 4-port SDRAM controller. Replaces fixed-priority port selection.
- Watches the fill levels of two write FIFOs and two read FIFOs. Selects one eligible port per burst and presents address, length and direction to the SDRAM command sequencer.
- Advances each port's address pointer with wrap-around when the burst-done pulse arrives.
- Ports 0 and 1 are write ports (SDRAM writes). Ports 2 and 3 are read ports (SDRAM reads).

---
 rtl/sdram_port_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sdram_port_scheduler.sv
// Round-robin burst scheduler for the 4-port SDRAM controller.
// Ports 0/1 feed SDRAM writes, ports 2/3 drain SDRAM reads. One eligible
// port is chosen per burst and its address/length/direction are presented
// to the command sequencer. The port's address pointer advances, with
// wrap-around, once the burst completes.
module sdram_port_scheduler #(
    parameter int ASIZE = 23,
    parameter int LSIZE = 10,
    parameter int USIZE = 16
) (
    input  logic               CTRL_CLK,
    input  logic               RESET,
    input  logic [3:0]         PORT_LOAD,
    input  logic [4*ASIZE-1:0] PORT_BASE,
    input  logic [4*ASIZE-1:0] PORT_MAX,
    input  logic [4*LSIZE-1:0] PORT_LEN,
    input  logic [4*USIZE-1:0] PORT_LEVEL,
    output logic               REQ,
    output logic               REQ_WR,
    output logic [ASIZE-1:0]   REQ_ADDR,
    output logic [LSIZE-1:0]   REQ_LEN,
    output logic [3:0]         REQ_MASK,
    input  logic               ACK,
    input  logic               DONE,
    output logic               IDLE
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BURST, S_UPD} state_t;

    state_t           state;
    logic [1:0]       rr_ptr;
    logic [1:0]       act;
    logic             load_hit;

    // Pointers are held as offsets from BASE, so reset and reload are a
    // plain clear and the current pointer is BASE + offset.
    logic [ASIZE-1:0] ofs    [4];
    logic [ASIZE-1:0] base_w [4];
    logic [ASIZE-1:0] max_w  [4];
    logic [ASIZE-1:0] ptr_w  [4];
    logic [LSIZE-1:0] len_w  [4];
    logic [USIZE-1:0] lvl_w  [4];
    logic [3:0]       elig;
    logic             found;
    logic [1:0]       win;

    // Offset of the next burst: advance by LEN while a full burst still
    // fits below MAX, otherwise wrap back to BASE (offset 0).
    function automatic logic [ASIZE-1:0] next_ofs(
        input logic [ASIZE-1:0] b,
        input logic [ASIZE-1:0] m,
        input logic [ASIZE-1:0] o,
        input logic [LSIZE-1:0] l
    );
        logic [ASIZE:0] ptr_x;
        logic [ASIZE:0] len_x;
        logic [ASIZE:0] lim_x;
        ptr_x = {1'b0, b} + {1'b0, o};
        len_x = (ASIZE + 1)'(l);
        if ({1'b0, m} < len_x) begin
            return '0;
        end
        lim_x = {1'b0, m} - len_x;
        if (ptr_x < lim_x) begin
            return o + ASIZE'(l);
        end
        return '0;
    endfunction

    // Unpack per-port fields and evaluate which ports could take a burst now.
    always_comb begin
        elig = '0;
        for (int i = 0; i < 4; i++) begin
            base_w[i] = PORT_BASE[i*ASIZE +: ASIZE];
            max_w[i]  = PORT_MAX[i*ASIZE +: ASIZE];
            len_w[i]  = PORT_LEN[i*LSIZE +: LSIZE];
            lvl_w[i]  = PORT_LEVEL[i*USIZE +: USIZE];
            ptr_w[i]  = base_w[i] + ofs[i];
            if (len_w[i] != '0 && !PORT_LOAD[i]) begin
                if (i < 2) begin
                    elig[i] = (lvl_w[i] >= USIZE'(len_w[i]));
                end else begin
                    elig[i] = (lvl_w[i] < USIZE'(len_w[i]));
                end
            end
        end
    end

    // Round-robin search starting at rr_ptr; first eligible port wins.
    always_comb begin
        found = 1'b0;
        win   = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!found && elig[rr_ptr + 2'(k)]) begin
                found = 1'b1;
                win   = rr_ptr + 2'(k);
            end
        end
    end

    // Scheduler FSM, registered request outputs and per-port pointers.
    always_ff @(posedge CTRL_CLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            act      <= '0;
            load_hit <= 1'b0;
            REQ      <= 1'b0;
            REQ_WR   <= 1'b0;
            REQ_ADDR <= '0;
            REQ_LEN  <= '0;
            REQ_MASK <= '0;
            for (int i = 0; i < 4; i++) begin
                ofs[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    load_hit <= 1'b0;
                    if (PORT_LOAD == 4'b0000 && found) begin
                        state    <= S_REQ;
                        act      <= win;
                        rr_ptr   <= win + 2'd1;
                        REQ      <= 1'b1;
                        REQ_WR   <= ~win[1];
                        REQ_ADDR <= ptr_w[win];
                        REQ_LEN  <= len_w[win];
                        REQ_MASK <= 4'b0001 << win;
                    end
                end
                S_REQ: begin
                    if (ACK) begin
                        REQ   <= 1'b0;
                        state <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (DONE) begin
                        state <= S_UPD;
                    end
                end
                S_UPD: begin
                    if (!load_hit && !PORT_LOAD[act]) begin
                        ofs[act] <= next_ofs(base_w[act], max_w[act], ofs[act], len_w[act]);
                    end
                    REQ_MASK <= '0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            // A reload of the active port during its burst pins it at BASE.
            if (state != S_IDLE && PORT_LOAD[act]) begin
                load_hit <= 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (PORT_LOAD[i]) begin
                    ofs[i] <= '0;
                end
            end
        end
    end

    assign IDLE = (state == S_IDLE);

endmodule
